// File: rtl/imem_loader_pkg.sv
// imem_loader_pkg
// Shared definitions for the instruction-memory loader: loader state
// encoding, frame layout constants and byte/word widths.
package imem_loader_pkg;

  localparam int BYTE_W   = 8;
  localparam int WORD_W   = 16;
  localparam int HDR_LEN  = 2;  // LEN_HI, LEN_LO
  localparam int CSUM_LEN = 1;  // trailing checksum byte

  typedef enum logic [2:0] {
    S_IDLE    = 3'd0,
    S_LEN_HI  = 3'd1,
    S_LEN_LO  = 3'd2,
    S_DATA_HI = 3'd3,
    S_DATA_LO = 3'd4,
    S_CSUM    = 3'd5,
    S_DONE    = 3'd6,
    S_ERR     = 3'd7
  } state_e;

endpackage

// File: rtl/imem_loader_if.sv
// imem_loader_if
// Groups the loader's byte-stream input and instruction-memory write port.
//   in_valid/in_data/in_ready : byte stream, transfer on valid && ready
//   imem_we/waddr/wdata       : one-cycle write strobe with address/data
// Modports:
//   slave  : the loader (sinks the byte stream, drives the memory write)
//   master : the environment (sources bytes, observes the memory write)
interface imem_loader_if #(
  parameter int ADDR_W = 8
);
  import imem_loader_pkg::*;

  logic                in_valid;
  logic [BYTE_W-1:0]   in_data;
  logic                in_ready;
  logic                imem_we;
  logic [ADDR_W-1:0]   imem_waddr;
  logic [WORD_W-1:0]   imem_wdata;

  modport slave (
    input  in_valid, in_data,
    output in_ready, imem_we, imem_waddr, imem_wdata
  );

  modport master (
    output in_valid, in_data,
    input  in_ready, imem_we, imem_waddr, imem_wdata
  );

endinterface

// File: rtl/imem_loader_word_assembler.sv
// word_assembler
// Holds the high byte of a big-endian pair, joins it with the incoming low
// byte, and keeps the running XOR of payload bytes.
//   clk, rst  : clock, async active-low reset
//   clr_i     : zero the XOR accumulator (start of a load)
//   hi_en_i   : capture byte_i as the high byte
//   acc_en_i  : fold byte_i into the XOR accumulator
//   byte_i    : current stream byte
//   word_o    : {captured high byte, byte_i}
//   xsum_o    : XOR accumulator
module word_assembler
  import imem_loader_pkg::*;
(
  input  logic              clk,
  input  logic              rst,
  input  logic              clr_i,
  input  logic              hi_en_i,
  input  logic              acc_en_i,
  input  logic [BYTE_W-1:0] byte_i,
  output logic [WORD_W-1:0] word_o,
  output logic [BYTE_W-1:0] xsum_o
);

  logic [BYTE_W-1:0] hi_q;
  logic [BYTE_W-1:0] xsum_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      hi_q   <= '0;
      xsum_q <= '0;
    end else begin
      if (hi_en_i) hi_q <= byte_i;
      if (clr_i)         xsum_q <= '0;
      else if (acc_en_i) xsum_q <= xsum_q ^ byte_i;
    end
  end

  assign word_o = {hi_q, byte_i};
  assign xsum_o = xsum_q;

endmodule

// File: rtl/imem_loader.sv
// imem_loader
// Loads a framed program image (LEN_HI LEN_LO {W_HI W_LO}*N CSUM) into the
// 16-bit instruction memory from address 0, holding the core in reset until
// a load completes with a matching XOR checksum.
//   clk, rst   : clock, async active-low reset
//   start      : one-cycle pulse, begins a load when idle
//   bus        : byte stream in, instruction-memory write out
//   cpu_rst    : active-high pipeline reset
//   busy       : load in progress
//   done / err : sticky result of the last load
//
// state     | meaning
// ----------+---------------------------------------------------
// S_IDLE    | waiting for start, stream not accepted
// S_LEN_HI  | expecting word-count high byte
// S_LEN_LO  | expecting word-count low byte, range-check N
// S_DATA_HI | expecting high byte of the next word
// S_DATA_LO | expecting low byte, write word on transfer
// S_CSUM    | expecting checksum byte
// S_DONE    | good image: flag done, release cpu_rst
// S_ERR     | bad length or checksum: flag err, keep cpu_rst
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int ADDR_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic start,
  imem_loader_if.slave bus,
  output logic cpu_rst,
  output logic busy,
  output logic done,
  output logic err
);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(DEPTH - 1);
  localparam logic [15:0]       DEPTH_N   = 16'(DEPTH);

  state_e              state_q, state_d;
  logic [ADDR_W-1:0]   addr_q, addr_d;
  logic [15:0]         left_q, left_d;
  logic                in_ready_q, in_ready_d;
  logic                we_q, we_d;
  logic [ADDR_W-1:0]   waddr_q, waddr_d;
  logic [WORD_W-1:0]   wdata_q, wdata_d;
  logic                cpu_rst_q, cpu_rst_d;
  logic                busy_q, busy_d;
  logic                done_q, done_d;
  logic                err_q, err_d;

  logic                xfer;
  logic                clr, hi_en, acc_en;
  logic [WORD_W-1:0]   word;
  logic [BYTE_W-1:0]   xsum;

  assign xfer = bus.in_valid && in_ready_q;

  // The high-byte register also holds LEN_HI, so word is N during LEN_LO.
  word_assembler u_asm (
    .clk      (clk),
    .rst      (rst),
    .clr_i    (clr),
    .hi_en_i  (hi_en),
    .acc_en_i (acc_en),
    .byte_i   (bus.in_data),
    .word_o   (word),
    .xsum_o   (xsum)
  );

  always_comb begin
    state_d   = state_q;
    addr_d    = addr_q;
    left_d    = left_q;
    we_d      = 1'b0;
    waddr_d   = waddr_q;
    wdata_d   = wdata_q;
    cpu_rst_d = cpu_rst_q;
    done_d    = done_q;
    err_d     = err_q;
    clr       = 1'b0;
    hi_en     = 1'b0;
    acc_en    = 1'b0;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d   = S_LEN_HI;
          done_d    = 1'b0;
          err_d     = 1'b0;
          addr_d    = '0;
          left_d    = '0;
          clr       = 1'b1;
          cpu_rst_d = 1'b1;
        end
      end
      S_LEN_HI: begin
        if (xfer) begin
          hi_en   = 1'b1;
          state_d = S_LEN_LO;
        end
      end
      S_LEN_LO: begin
        if (xfer) begin
          left_d = word;
          if (word > DEPTH_N)    state_d = S_ERR;
          else if (word == '0)   state_d = S_CSUM;
          else                   state_d = S_DATA_HI;
        end
      end
      S_DATA_HI: begin
        if (xfer) begin
          hi_en   = 1'b1;
          acc_en  = 1'b1;
          state_d = S_DATA_LO;
        end
      end
      S_DATA_LO: begin
        if (xfer) begin
          acc_en  = 1'b1;
          we_d    = 1'b1;
          waddr_d = addr_q;
          wdata_d = word;
          addr_d  = (addr_q == LAST_ADDR) ? '0 : addr_q + 1'b1;
          left_d  = left_q - 16'd1;
          state_d = (left_q == 16'd1) ? S_CSUM : S_DATA_HI;
        end
      end
      S_CSUM: begin
        if (xfer) state_d = (bus.in_data == xsum) ? S_DONE : S_ERR;
      end
      S_DONE: begin
        done_d    = 1'b1;
        cpu_rst_d = 1'b0;
        state_d   = S_IDLE;
      end
      S_ERR: begin
        err_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase

    // Registered status outputs track the state being entered.
    in_ready_d = (state_d == S_LEN_HI)  || (state_d == S_LEN_LO) ||
                 (state_d == S_DATA_HI) || (state_d == S_DATA_LO) ||
                 (state_d == S_CSUM);
    busy_d     = (state_d != S_IDLE);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= S_IDLE;
      addr_q     <= '0;
      left_q     <= '0;
      in_ready_q <= 1'b0;
      we_q       <= 1'b0;
      waddr_q    <= '0;
      wdata_q    <= '0;
      cpu_rst_q  <= 1'b1;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      left_q     <= left_d;
      in_ready_q <= in_ready_d;
      we_q       <= we_d;
      waddr_q    <= waddr_d;
      wdata_q    <= wdata_d;
      cpu_rst_q  <= cpu_rst_d;
      busy_q     <= busy_d;
      done_q     <= done_d;
      err_q      <= err_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.imem_we    = we_q;
  assign bus.imem_waddr = waddr_q;
  assign bus.imem_wdata = wdata_q;
  assign cpu_rst        = cpu_rst_q;
  assign busy           = busy_q;
  assign done           = done_q;
  assign err            = err_q;

endmodule

// File: tb/tb_imem_loader.sv
// Bench for imem_loader: a byte-index frame model predicts every output on
// every cycle; literal expectations pin the results of each directed frame.
module tb_imem_loader;
  import imem_loader_pkg::*;

  localparam int ADDR_W = 8;
  localparam int DEPTH  = 256;

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic start = 1'b0;
  logic cpu_rst, busy, done, err;

  imem_loader_if #(.ADDR_W(ADDR_W)) bus ();

  imem_loader #(.ADDR_W(ADDR_W), .DEPTH(DEPTH)) dut (
    .clk     (clk),
    .rst     (rst),
    .start   (start),
    .bus     (bus),
    .cpu_rst (cpu_rst),
    .busy    (busy),
    .done    (done),
    .err     (err)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  logic [7:0]  fq[$];
  logic [15:0] mem [DEPTH];
  int          wr_count = 0;

  // model state: phase 0 idle, 1 receiving, 2 finishing good, 3 finishing bad
  int          m_ph = 0;
  int          m_k  = 0;
  int          m_n  = 0;
  logic [7:0]  m_hi = '0;
  logic [7:0]  m_x  = '0;
  logic        exp_ready, exp_we, exp_busy, exp_done, exp_err, exp_cpu_rst;
  logic [7:0]  exp_waddr;
  logic [15:0] exp_wdata;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] expv);
    n_assert++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h at %0t", nm, act, expv, $time);
    end
  endtask

  task automatic model_reset();
    m_ph = 0; m_k = 0; m_n = 0; m_hi = '0; m_x = '0;
    exp_ready = 1'b0; exp_we = 1'b0; exp_busy = 1'b0;
    exp_done = 1'b0; exp_err = 1'b0; exp_cpu_rst = 1'b1;
    exp_waddr = '0; exp_wdata = '0;
  endtask

  // Advances the model by one clock edge, based on the byte index into the frame.
  task automatic model_step();
    bit x;
    x = bus.in_valid && exp_ready;
    exp_we = 1'b0;
    case (m_ph)
      0: if (start) begin
        m_ph = 1; m_k = 0; m_x = '0;
        exp_done = 1'b0; exp_err = 1'b0; exp_cpu_rst = 1'b1;
      end
      1: if (x) begin
        if (m_k == 0) m_hi = bus.in_data;
        else if (m_k == 1) begin
          m_n = int'({m_hi, bus.in_data});
          if (m_n > DEPTH) m_ph = 3;
        end else if (m_k < 2 + 2 * m_n) begin
          m_x = m_x ^ bus.in_data;
          if ((m_k % 2) == 1) begin
            exp_we    = 1'b1;
            exp_waddr = 8'(((m_k - 3) / 2) % DEPTH);
            exp_wdata = {m_hi, bus.in_data};
          end else m_hi = bus.in_data;
        end else m_ph = (bus.in_data == m_x) ? 2 : 3;
        m_k++;
      end
      2: begin exp_done = 1'b1; exp_cpu_rst = 1'b0; m_ph = 0; end
      default: begin exp_err = 1'b1; m_ph = 0; end
    endcase
    exp_busy  = (m_ph != 0);
    exp_ready = (m_ph == 1);
  endtask

  initial begin
    model_reset();
    forever begin
      @(posedge clk or negedge rst);
      if (!rst) model_reset();
      else model_step();
    end
  end

  // Per-cycle compare and write capture.
  initial forever begin
    @(negedge clk);
    if (rst) begin
      chk("in_ready", 32'(bus.in_ready), 32'(exp_ready));
      chk("imem_we",  32'(bus.imem_we),  32'(exp_we));
      chk("busy",     32'(busy),         32'(exp_busy));
      chk("done",     32'(done),         32'(exp_done));
      chk("err",      32'(err),          32'(exp_err));
      chk("cpu_rst",  32'(cpu_rst),      32'(exp_cpu_rst));
      if (exp_we) begin
        chk("imem_waddr", 32'(bus.imem_waddr), 32'(exp_waddr));
        chk("imem_wdata", 32'(bus.imem_wdata), 32'(exp_wdata));
      end
      if (bus.imem_we) begin
        mem[bus.imem_waddr] = bus.imem_wdata;
        wr_count++;
      end
    end
  end

  task automatic run_frame(input int max_x, input bit stall, input bit poke);
    int sent = 0;
    int budget = 0;
    bit v;
    wr_count = 0;
    @(negedge clk); start = 1'b1;
    @(negedge clk); start = 1'b0;
    while (fq.size() > 0 && sent < max_x && budget < 4000) begin
      @(negedge clk);
      budget++;
      v = stall ? ($urandom_range(0, 2) != 0) : 1'b1;
      start = poke && ((budget % 4) == 2);
      bus.in_valid = v;
      bus.in_data  = fq[0];
      if (v && bus.in_ready) begin
        if (poke && fq.size() == 1) start = 1'b1;  // coincides with CSUM transfer
        void'(fq.pop_front());
        sent++;
      end
    end
    if (budget >= 4000) begin
      n_assert++; n_fail++;
      $display("FAIL frame_timeout: got %0d bytes sent, expected frame to drain", sent);
    end
    @(negedge clk); bus.in_valid = 1'b0; start = 1'b0;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("rst_busy",    32'(busy),    32'd0);
    chk("rst_ready",   32'(bus.in_ready), 32'd0);
    chk("rst_wdata",   32'(bus.imem_wdata), 32'd0);
    rst = 1'b1;

    // good 3-word load, start poked on the CSUM transfer
    fq = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'h41};
    run_frame(1000, 1'b0, 1'b1);
    #1;
    chk("good_writes", 32'(wr_count), 32'd3);
    chk("good_mem0", 32'(mem[0]), 32'h1234);
    chk("good_mem1", 32'(mem[1]), 32'hABCD);
    chk("good_mem2", 32'(mem[2]), 32'h0001);
    chk("good_done", 32'(done), 32'd1);
    chk("good_cpu_rst", 32'(cpu_rst), 32'd0);

    // bad checksum
    fq = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'h40};
    run_frame(1000, 1'b0, 1'b0);
    #1;
    chk("bad_writes", 32'(wr_count), 32'd3);
    chk("bad_err", 32'(err), 32'd1);
    chk("bad_done", 32'(done), 32'd0);
    chk("bad_cpu_rst", 32'(cpu_rst), 32'd1);

    // oversize N = 257
    fq = '{8'h01, 8'h01};
    run_frame(1000, 1'b0, 1'b0);
    #1;
    chk("over_writes", 32'(wr_count), 32'd0);
    chk("over_err", 32'(err), 32'd1);
    chk("over_ready", 32'(bus.in_ready), 32'd0);

    // empty image
    fq = '{8'h00, 8'h00, 8'h00};
    run_frame(1000, 1'b0, 1'b0);
    #1;
    chk("empty_writes", 32'(wr_count), 32'd0);
    chk("empty_done", 32'(done), 32'd1);
    chk("empty_err", 32'(err), 32'd0);

    // 4 words with random stalls and mid-load start pulses, CSUM 0x7D
    fq = '{8'h00, 8'h04, 8'h01, 8'h02, 8'hA5, 8'hA5, 8'hFF, 8'hFF, 8'h7E, 8'h00, 8'h7D};
    run_frame(1000, 1'b1, 1'b1);
    #1;
    chk("stall_writes", 32'(wr_count), 32'd4);
    chk("stall_mem0", 32'(mem[0]), 32'h0102);
    chk("stall_mem1", 32'(mem[1]), 32'hA5A5);
    chk("stall_mem2", 32'(mem[2]), 32'hFFFF);
    chk("stall_mem3", 32'(mem[3]), 32'h7E00);
    chk("stall_done", 32'(done), 32'd1);

    // full-depth image N = DEPTH, word i = {i, ~i}, checksum 0x00
    fq.delete();
    fq.push_back(8'h01);
    fq.push_back(8'h00);
    for (int i = 0; i < DEPTH; i++) begin
      fq.push_back(8'(i));
      fq.push_back(~8'(i));
    end
    fq.push_back(8'h00);
    run_frame(1000, 1'b0, 1'b0);
    #1;
    chk("full_writes", 32'(wr_count), 32'd256);
    chk("full_mem255", 32'(mem[255]), 32'hFF00);
    chk("full_done", 32'(done), 32'd1);

    // reset after word 1 written, then reload
    fq = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'h41};
    run_frame(6, 1'b0, 1'b0);
    chk("mid_writes", 32'(wr_count), 32'd2);
    #1 rst = 1'b0;
    #1;
    chk("mid_rst_cpu_rst", 32'(cpu_rst), 32'd1);
    chk("mid_rst_busy", 32'(busy), 32'd0);
    chk("mid_rst_ready", 32'(bus.in_ready), 32'd0);
    chk("mid_rst_we", 32'(bus.imem_we), 32'd0);
    chk("mid_rst_waddr", 32'(bus.imem_waddr), 32'd0);
    chk("mid_rst_wdata", 32'(bus.imem_wdata), 32'd0);
    chk("mid_rst_done", 32'(done), 32'd0);
    chk("mid_rst_err", 32'(err), 32'd0);
    @(negedge clk); #2 rst = 1'b1;
    mem[0] = '0;
    fq = '{8'h00, 8'h03, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00, 8'h01, 8'h41};
    run_frame(1000, 1'b0, 1'b0);
    #1;
    chk("reload_writes", 32'(wr_count), 32'd3);
    chk("reload_mem0", 32'(mem[0]), 32'h1234);
    chk("reload_done", 32'(done), 32'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

  initial begin
    #600000;
    $display("FAIL watchdog: got timeout, expected test completion");
    $fatal(1, "watchdog expired");
  end

endmodule
